// File: rtl/edge_wb_arbiter.sv
// edge_wb_arbiter
// Round-robin arbiter that shares the single output-SRAM write port among
// NUM_BANK edge buffer banks. A granted bank keeps the port for its whole
// sos..eos stream; its beats are forwarded through one register stage. A
// watchdog releases the grant if the owner stays silent for TIMEOUT cycles.

module edge_wb_arbiter #(
   parameter int NUM_BANK  = 4,
   parameter int NODE_ID_W = 8,
   parameter int DATA_W    = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_BANK-1:0]           bank_req,
   input  logic [NUM_BANK-1:0]           bank_valid,
   input  logic [NUM_BANK-1:0]           bank_sos,
   input  logic [NUM_BANK-1:0]           bank_eos,
   input  logic [NUM_BANK*DATA_W-1:0]    bank_data,
   input  logic [NUM_BANK*NODE_ID_W-1:0] bank_node_id,
   output logic [NUM_BANK-1:0]           req_grant,
   output logic                          sram_valid,
   output logic                          sram_sos,
   output logic                          sram_eos,
   output logic [DATA_W-1:0]             sram_data,
   output logic [NODE_ID_W-1:0]          sram_node_id,
   output logic [$clog2(NUM_BANK)-1:0]   sram_bank_id,
   output logic                          busy,
   output logic                          timeout_err,
   output logic [$clog2(NUM_BANK)-1:0]   err_bank
);

   localparam int BID_W = $clog2(NUM_BANK);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [BID_W-1:0] LAST_BANK = BID_W'(NUM_BANK - 1);

   // First requester at or after ptr, searching cyclically.
   function automatic logic [BID_W-1:0] rr_pick(input logic [NUM_BANK-1:0] req,
                                                input logic [BID_W-1:0]    ptr);
      logic [BID_W-1:0] pick;
      logic [BID_W-1:0] idx;
      logic             found;
      pick  = {BID_W{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NUM_BANK; i++) begin
         idx = BID_W'((int'(ptr) + i) % NUM_BANK);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   // One-hot decode of a bank index.
   function automatic logic [NUM_BANK-1:0] onehot(input logic [BID_W-1:0] b);
      return {{(NUM_BANK-1){1'b0}}, 1'b1} << b;
   endfunction

   // Bank index following b, wrapping for non-power-of-two bank counts.
   function automatic logic [BID_W-1:0] next_bank(input logic [BID_W-1:0] b);
      return (b == LAST_BANK) ? {BID_W{1'b0}} : b + BID_W'(1);
   endfunction

   // Registered state
   logic [0:0]       state_r;
   logic [BID_W-1:0] owner_r;
   logic [BID_W-1:0] rr_ptr_r;
   logic [CNT_W-1:0] idle_cnt_r;

   // Next-state values
   logic [0:0]           state_s;
   logic [BID_W-1:0]     owner_s;
   logic [BID_W-1:0]     rr_ptr_s;
   logic [CNT_W-1:0]     idle_cnt_s;
   logic [NUM_BANK-1:0]  grant_s;
   logic                 valid_s;
   logic                 sos_s;
   logic                 eos_s;
   logic [DATA_W-1:0]    data_s;
   logic [NODE_ID_W-1:0] node_id_s;
   logic [BID_W-1:0]     bank_id_s;
   logic                 terr_s;
   logic [BID_W-1:0]     err_bank_s;

   // Arbitration and owner-side views
   logic [BID_W-1:0]     winner_s;
   logic [CNT_W-1:0]     idle_inc_s;
   logic                 own_valid_s;
   logic                 own_sos_s;
   logic                 own_eos_s;
   logic [DATA_W-1:0]    own_data_s;
   logic [NODE_ID_W-1:0] own_node_id_s;

   logic [DATA_W-1:0]    data_arr_s    [NUM_BANK];
   logic [NODE_ID_W-1:0] node_id_arr_s [NUM_BANK];

   genvar g;
   generate
      for (g = 0; g < NUM_BANK; g++) begin : g_unpack
         assign data_arr_s[g]    = bank_data[g*DATA_W +: DATA_W];
         assign node_id_arr_s[g] = bank_node_id[g*NODE_ID_W +: NODE_ID_W];
      end
   endgenerate

   // Select the owner's beat; every other bank's signals are ignored.
   always_comb begin
      own_valid_s   = bank_valid[owner_r];
      own_sos_s     = bank_sos[owner_r];
      own_eos_s     = bank_eos[owner_r];
      own_data_s    = data_arr_s[owner_r];
      own_node_id_s = node_id_arr_s[owner_r];
   end

   // Round-robin winner and the saturating idle-counter increment.
   always_comb begin
      winner_s   = rr_pick(bank_req, rr_ptr_r);
      idle_inc_s = (idle_cnt_r == TIMEOUT_C) ? idle_cnt_r : idle_cnt_r + CNT_W'(1);
   end

   // Next-state decode for arbitration, forwarding and watchdog.
   always_comb begin
      state_s    = state_r;
      owner_s    = owner_r;
      rr_ptr_s   = rr_ptr_r;
      idle_cnt_s = idle_cnt_r;
      grant_s    = {NUM_BANK{1'b0}};
      valid_s    = 1'b0;
      sos_s      = 1'b0;
      eos_s      = 1'b0;
      data_s     = {DATA_W{1'b0}};
      node_id_s  = {NODE_ID_W{1'b0}};
      bank_id_s  = {BID_W{1'b0}};
      terr_s     = timeout_err;
      err_bank_s = err_bank;

      case (state_r)
         ST_IDLE: begin
            if (|bank_req) begin
               state_s    = ST_GRANT;
               grant_s    = onehot(winner_s);
               owner_s    = winner_s;
               rr_ptr_s   = next_bank(winner_s);
               idle_cnt_s = {CNT_W{1'b0}};
            end else begin
               state_s    = ST_IDLE;
            end
         end

         ST_GRANT: begin
            if (own_valid_s) begin
               // A beat always wins over the watchdog in the same cycle.
               valid_s    = 1'b1;
               sos_s      = own_sos_s;
               eos_s      = own_eos_s;
               data_s     = own_data_s;
               node_id_s  = own_node_id_s;
               bank_id_s  = owner_r;
               idle_cnt_s = {CNT_W{1'b0}};
               if (own_eos_s) begin
                  state_s = ST_IDLE;
                  grant_s = {NUM_BANK{1'b0}};
               end else begin
                  grant_s = onehot(owner_r);
               end
            end else if (idle_inc_s == TIMEOUT_C) begin
               // Owner stalled: drop the grant without a closing beat.
               state_s    = ST_IDLE;
               grant_s    = {NUM_BANK{1'b0}};
               idle_cnt_s = idle_inc_s;
               terr_s     = 1'b1;
               err_bank_s = owner_r;
            end else begin
               idle_cnt_s = idle_inc_s;
               grant_s    = onehot(owner_r);
            end
         end

         default: begin
            state_s    = ST_IDLE;
            grant_s    = {NUM_BANK{1'b0}};
            idle_cnt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and output registers; reset drops any grant immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= {BID_W{1'b0}};
         rr_ptr_r     <= {BID_W{1'b0}};
         idle_cnt_r   <= {CNT_W{1'b0}};
         req_grant    <= {NUM_BANK{1'b0}};
         sram_valid   <= 1'b0;
         sram_sos     <= 1'b0;
         sram_eos     <= 1'b0;
         sram_data    <= {DATA_W{1'b0}};
         sram_node_id <= {NODE_ID_W{1'b0}};
         sram_bank_id <= {BID_W{1'b0}};
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         err_bank     <= {BID_W{1'b0}};
      end else begin
         state_r      <= state_s;
         owner_r      <= owner_s;
         rr_ptr_r     <= rr_ptr_s;
         idle_cnt_r   <= idle_cnt_s;
         req_grant    <= grant_s;
         sram_valid   <= valid_s;
         sram_sos     <= sos_s;
         sram_eos     <= eos_s;
         sram_data    <= data_s;
         sram_node_id <= node_id_s;
         sram_bank_id <= bank_id_s;
         busy         <= (state_s == ST_GRANT);
         timeout_err  <= terr_s;
         err_bank     <= err_bank_s;
      end
   end

   edge_wb_arbiter_chk #(
      .NUM_BANK  (NUM_BANK),
      .NODE_ID_W (NODE_ID_W),
      .DATA_W    (DATA_W)
   ) u_chk (
      .clk          (clk),
      .reset        (reset),
      .req_grant    (req_grant),
      .busy         (busy),
      .sram_valid   (sram_valid),
      .sram_sos     (sram_sos),
      .sram_eos     (sram_eos),
      .sram_data    (sram_data),
      .sram_node_id (sram_node_id),
      .sram_bank_id (sram_bank_id)
   );

endmodule

// edge_wb_arbiter_chk
// Structural invariants of the arbiter outputs.
module edge_wb_arbiter_chk #(
   parameter int NUM_BANK  = 4,
   parameter int NODE_ID_W = 8,
   parameter int DATA_W    = 16
) (
   input logic                        clk,
   input logic                        reset,
   input logic [NUM_BANK-1:0]         req_grant,
   input logic                        busy,
   input logic                        sram_valid,
   input logic                        sram_sos,
   input logic                        sram_eos,
   input logic [DATA_W-1:0]           sram_data,
   input logic [NODE_ID_W-1:0]        sram_node_id,
   input logic [$clog2(NUM_BANK)-1:0] sram_bank_id
);

   // Grant is one-hot or idle, tracks busy, and idle beats carry zeros.
   always @(posedge clk) begin
      if (!reset) begin
         assert ($onehot0(req_grant));
         assert (busy == (req_grant != {NUM_BANK{1'b0}}));
         assert (sram_valid || (!sram_sos && !sram_eos && sram_data == {DATA_W{1'b0}} &&
                                sram_node_id == {NODE_ID_W{1'b0}} && sram_bank_id == '0));
      end
   end

endmodule

// File: tb/tb_edge_wb_arbiter.sv
// tb_edge_wb_arbiter
// Directed test of edge_wb_arbiter: single stream, round-robin order,
// contention during a stream, non-owner noise, watchdog and async reset.

module tb_edge_wb_arbiter;

   localparam int NB = 4;
   localparam int NW = 8;
   localparam int DW = 16;
   localparam int TO = 15;

   logic               clk;
   logic               reset;
   logic [NB-1:0]      bank_req;
   logic [NB-1:0]      bank_valid;
   logic [NB-1:0]      bank_sos;
   logic [NB-1:0]      bank_eos;
   logic [NB*DW-1:0]   bank_data;
   logic [NB*NW-1:0]   bank_node_id;
   logic [NB-1:0]      req_grant;
   logic               sram_valid;
   logic               sram_sos;
   logic               sram_eos;
   logic [DW-1:0]      sram_data;
   logic [NW-1:0]      sram_node_id;
   logic [1:0]         sram_bank_id;
   logic               busy;
   logic               timeout_err;
   logic [1:0]         err_bank;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   edge_wb_arbiter #(
      .NUM_BANK (NB), .NODE_ID_W (NW), .DATA_W (DW), .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bank_req     (bank_req),
      .bank_valid   (bank_valid),
      .bank_sos     (bank_sos),
      .bank_eos     (bank_eos),
      .bank_data    (bank_data),
      .bank_node_id (bank_node_id),
      .req_grant    (req_grant),
      .sram_valid   (sram_valid),
      .sram_sos     (sram_sos),
      .sram_eos     (sram_eos),
      .sram_data    (sram_data),
      .sram_node_id (sram_node_id),
      .sram_bank_id (sram_bank_id),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .err_bank     (err_bank)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL sim_timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_sram(input string tag, input logic v, input logic s, input logic e,
                           input logic [15:0] d, input logic [7:0] n, input logic [1:0] b);
      chk({tag, ".valid"},   32'(sram_valid),   32'(v));
      chk({tag, ".sos"},     32'(sram_sos),     32'(s));
      chk({tag, ".eos"},     32'(sram_eos),     32'(e));
      chk({tag, ".data"},    32'(sram_data),    32'(d));
      chk({tag, ".node_id"}, 32'(sram_node_id), 32'(n));
      chk({tag, ".bank_id"}, 32'(sram_bank_id), 32'(b));
   endtask

   task automatic set_beat(input int b, input logic v, input logic s, input logic e,
                           input logic [15:0] d, input logic [7:0] n);
      bank_valid[b]          = v;
      bank_sos[b]            = s;
      bank_eos[b]            = e;
      bank_data[b*DW +: DW]  = d;
      bank_node_id[b*NW +: NW] = n;
   endtask

   initial begin
      reset        = 1'b1;
      bank_req     = 4'b0000;
      bank_valid   = 4'b0000;
      bank_sos     = 4'b0000;
      bank_eos     = 4'b0000;
      bank_data    = 64'h0;
      bank_node_id = 32'h0;

      // Reset state
      step();
      chk("rst.grant", 32'(req_grant), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.terr", 32'(timeout_err), 32'h0);
      chk("rst.err_bank", 32'(err_bank), 32'h0);
      chk_sram("rst", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0);
      reset = 1'b0;

      // Single request from bank 1, three-beat stream
      bank_req = 4'b0010;
      step();
      chk("t1.grant", 32'(req_grant), 32'h2);
      chk("t1.busy", 32'(busy), 32'h1);
      chk("t1.nobeat", 32'(sram_valid), 32'h0);
      bank_req = 4'b0000;
      set_beat(1, 1'b1, 1'b1, 1'b0, 16'hA1B2, 8'h07);
      step();
      chk_sram("t1.b0", 1'b1, 1'b1, 1'b0, 16'hA1B2, 8'h07, 2'd1);
      chk("t1.grant_b0", 32'(req_grant), 32'h2);
      set_beat(1, 1'b1, 1'b0, 1'b0, 16'h0304, 8'h07);
      step();
      chk_sram("t1.b1", 1'b1, 1'b0, 1'b0, 16'h0304, 8'h07, 2'd1);
      set_beat(1, 1'b1, 1'b0, 1'b1, 16'h0506, 8'h07);
      step();
      chk_sram("t1.b2", 1'b1, 1'b0, 1'b1, 16'h0506, 8'h07, 2'd1);
      chk("t1.release", 32'(req_grant), 32'h0);
      chk("t1.busy_off", 32'(busy), 32'h0);
      set_beat(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      chk_sram("t1.idle", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0);
      chk("t1.idle_grant", 32'(req_grant), 32'h0);

      // Round-robin from a fresh pointer: order 0,1,2,3,0
      reset = 1'b1;
      step();
      reset = 1'b0;
      bank_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("rr%0d.grant", k), 32'(req_grant), 32'(4'b0001 << (k % 4)));
         set_beat(k % 4, 1'b1, 1'b1, 1'b1, 16'h1000 + 16'(k), 8'h20 + 8'(k));
         step();
         chk($sformatf("rr%0d.release", k), 32'(req_grant), 32'h0);
         chk_sram($sformatf("rr%0d", k), 1'b1, 1'b1, 1'b1, 16'h1000 + 16'(k),
                  8'h20 + 8'(k), 2'(k % 4));
         set_beat(k % 4, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      end
      bank_req = 4'b0000;
      step();
      chk("rr.idle", 32'(req_grant), 32'h0);

      // Bank 0 streams; bank 2 requests mid-stream; bank 3 drives noise
      bank_req = 4'b0001;
      step();
      chk("t3.grant0", 32'(req_grant), 32'h1);
      bank_req = 4'b0101;
      set_beat(0, 1'b1, 1'b1, 1'b0, 16'h1111, 8'h33);
      set_beat(3, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h44);
      step();
      chk_sram("t3.b0", 1'b1, 1'b1, 1'b0, 16'h1111, 8'h33, 2'd0);
      chk("t3.hold0", 32'(req_grant), 32'h1);
      set_beat(0, 1'b1, 1'b0, 1'b0, 16'h2222, 8'h33);
      step();
      chk_sram("t3.b1", 1'b1, 1'b0, 1'b0, 16'h2222, 8'h33, 2'd0);
      set_beat(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      chk_sram("t3.noise", 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0);
      chk("t3.hold1", 32'(req_grant), 32'h1);
      set_beat(0, 1'b1, 1'b0, 1'b1, 16'h3333, 8'h33);
      step();
      chk_sram("t3.b2", 1'b1, 1'b0, 1'b1, 16'h3333, 8'h33, 2'd0);
      chk("t3.release", 32'(req_grant), 32'h0);
      set_beat(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      set_beat(3, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      bank_req = 4'b0100;
      step();
      chk("t3.grant2", 32'(req_grant), 32'h4);
      chk("t3.grant2_nobeat", 32'(sram_valid), 32'h0);

      // Watchdog: bank 2 silent for TIMEOUT cycles
      bank_req = 4'b0000;
      repeat (TO - 1) step();
      chk("t4.still_held", 32'(req_grant), 32'h4);
      chk("t4.no_err_yet", 32'(timeout_err), 32'h0);
      step();
      chk("t4.forced_release", 32'(req_grant), 32'h0);
      chk("t4.terr", 32'(timeout_err), 32'h1);
      chk("t4.err_bank", 32'(err_bank), 32'h2);
      chk("t4.busy", 32'(busy), 32'h0);
      chk("t4.nobeat", 32'(sram_valid), 32'h0);

      // Beat exactly on the would-be timeout cycle keeps the grant
      bank_req = 4'b0100;
      step();
      chk("t4b.grant", 32'(req_grant), 32'h4);
      bank_req = 4'b0000;
      repeat (TO - 1) step();
      chk("t4b.held14", 32'(req_grant), 32'h4);
      set_beat(2, 1'b1, 1'b1, 1'b0, 16'h5A5A, 8'h55);
      step();
      chk("t4b.saved", 32'(req_grant), 32'h4);
      chk_sram("t4b.beat", 1'b1, 1'b1, 1'b0, 16'h5A5A, 8'h55, 2'd2);
      chk("t4b.terr_sticky", 32'(timeout_err), 32'h1);
      set_beat(2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      repeat (TO - 1) step();
      chk("t4b.restarted", 32'(req_grant), 32'h4);
      step();
      chk("t4b.release", 32'(req_grant), 32'h0);
      chk("t4b.err_bank", 32'(err_bank), 32'h2);

      // Async reset during bank 1's second beat
      bank_req = 4'b0010;
      step();
      chk("t5.grant", 32'(req_grant), 32'h2);
      bank_req = 4'b0000;
      set_beat(1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 8'h11);
      step();
      chk_sram("t5.b0", 1'b1, 1'b1, 1'b0, 16'hAAAA, 8'h11, 2'd1);
      set_beat(1, 1'b1, 1'b0, 1'b0, 16'hBBBB, 8'h11);
      #2;
      reset = 1'b1;
      #1;
      chk("t5.rst_grant", 32'(req_grant), 32'h0);
      chk("t5.rst_valid", 32'(sram_valid), 32'h0);
      chk("t5.rst_data", 32'(sram_data), 32'h0);
      chk("t5.rst_busy", 32'(busy), 32'h0);
      chk("t5.rst_terr", 32'(timeout_err), 32'h0);
      set_beat(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      reset = 1'b0;
      bank_req = 4'b1010;
      step();
      chk("t5.ptr0_grant", 32'(req_grant), 32'h2);
      chk("t5.ptr0_nobeat", 32'(sram_valid), 32'h0);
      bank_req = 4'b0000;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/edge_wb_arbiter.md
Name: edge_wb_arbiter

Overview:
- Round-robin arbiter sharing the single output-SRAM write port among NUM_BANK edge buffer banks.
- Each bank raises a write-back request and waits for a grant. Once granted, the bank streams 2×8-bit feature-value beats framed by sos/eos. The arbiter forwards the beats, registered, to the output SRAM request path.
- The grant is held for the whole stream and released on eos. A watchdog also releases it if the granted bank stalls.

Parameters:
- NUM_BANK, 4, number of requesting edge buffer banks (≥2).
- NODE_ID_W, 8, node id width.
- DATA_W, 16, beat width (two 8-bit FVs; [15:8] = even FV, [7:0] = odd FV).
- TIMEOUT, 15, max consecutive idle cycles allowed while granted before forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- bank_req  in  NUM_BANK  per-bank write-back request (level).
- bank_valid  in  NUM_BANK  per-bank beat valid (Grant_valid).
- bank_sos  in  NUM_BANK  per-bank start of stream.
- bank_eos  in  NUM_BANK  per-bank end of stream.
- bank_data  in  NUM_BANK*DATA_W  per-bank beat data, bank i at [i*DATA_W +: DATA_W].
- bank_node_id  in  NUM_BANK*NODE_ID_W  per-bank node id.
- req_grant  out  NUM_BANK  one-hot grant, registered.
- sram_valid  out  1  forwarded beat valid.
- sram_sos  out  1  forwarded sos.
- sram_eos  out  1  forwarded eos.
- sram_data  out  DATA_W  forwarded data.
- sram_node_id  out  NODE_ID_W  forwarded node id.
- sram_bank_id  out  $clog2(NUM_BANK)  source bank of the forwarded beat.
- busy  out  1  high while in GRANT.
- timeout_err  out  1  sticky; set on watchdog release, cleared only by reset.
- err_bank  out  $clog2(NUM_BANK)  bank that caused the last timeout.

Behaviour:
- Reset (async) clears all outputs and state: req_grant = 0, all sram_* = 0, busy = 0, timeout_err = 0, err_bank = 0, rr_ptr = 0, idle_cnt = 0, state = IDLE. Reset mid-stream drops the grant immediately; nothing is forwarded.

State IDLE:
- If any bank_req is high, select the first requester at or after rr_ptr (cyclic search).
- Next cycle: req_grant = onehot(winner), owner = winner, rr_ptr = winner+1 mod NUM_BANK, state = GRANT, idle_cnt = 0.
- If no request, stay in IDLE.
- Grant latency: 1 cycle after the first sampled req.

State GRANT:
- req_grant stays at onehot(owner). Requests from other banks are held pending; they are not lost because the request is a level.
- Only the owner's bank_valid/sos/eos/data/node_id are observed. All other banks' valid is ignored.
- Owner valid beat: on the next cycle drive sram_valid = 1 with sos/eos/data/node_id copied and sram_bank_id = owner (1-cycle pipeline). Reset idle_cnt to 0.
- No owner valid: sram_valid = 0 next cycle (sram_sos/eos also 0); idle_cnt += 1.
- Owner valid && eos, including a single beat with sos && eos: the beat is forwarded, req_grant = 0 next cycle, state = IDLE. The next grant can issue one cycle after that (minimum one bubble cycle between streams).
- idle_cnt reaches TIMEOUT:
  - req_grant = 0 and state = IDLE on the next cycle.
  - timeout_err = 1, err_bank = owner.
  - A synthetic closing beat is not generated.
- The owner's valid in the same cycle the timeout fires takes priority: the beat is forwarded and the timeout does not fire.
- bank_req from the owner while in GRANT is ignored. If it is still high in IDLE, it competes normally and rr_ptr makes it lowest priority.

Other rules:
- Data, node id and flags pass through unmodified; no arithmetic on the datapath.
- idle_cnt is wide enough for TIMEOUT and saturates.
- sram_* outputs hold 0 whenever sram_valid = 0.
- busy = (state == GRANT).

Test Plan:
- Single request: bank_req = 0010 at cycle 0 → req_grant = 0010 at cycle 1. Bank 1 sends 3 beats (sos on 0xA1B2, middle 0x0304, eos on 0x0506), node 7 → sram_valid for 3 cycles, delayed by 1, with sram_bank_id = 1. req_grant = 0 the cycle after eos.
- Round-robin fairness: bank_req = 1111 held; each bank streams a 1-beat sos+eos transfer → grant order 0, 1, 2, 3, 0. Each grant lasts 1 cycle, with a 1-cycle IDLE gap between grants.
- Concurrent request during a stream: bank 0 is granted; bank 2 raises req mid-stream → req_grant stays 0001 until eos. Then 0100 is granted 2 cycles after the eos beat is sampled.
- Non-owner noise: while bank 0 owns the grant, bank 3 drives valid = 1, data = 0xFFFF → sram_data never shows 0xFFFF and sram_bank_id stays 0.
- Watchdog: bank 2 is granted and never asserts valid → after 15 idle cycles req_grant = 0, timeout_err = 1, err_bank = 2. A valid beat arriving exactly at cycle 15 prevents the timeout.
- Async reset mid-stream: assert reset during the second beat of bank 1 → req_grant, sram_valid and busy are 0 immediately. After release, the next request from bank 1 is arbitrated from rr_ptr = 0.
